// File: rtl/adv_video_pkg.sv
// Shared constants for the ADV7511 video timing generator: 720p defaults,
// coordinate width, colour-bar palette and the per-pixel timing flag bundle.
package adv_video_pkg;

    localparam int COORD_W   = 12;
    localparam int MAX_TOTAL = 1 << COORD_W;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;

    localparam int NUM_BARS = 8;
    localparam logic [23:0] BAR_COLOURS [NUM_BARS] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // Timing flags carried down the shift chain; syncs are kept as "asserted"
    // and only mapped to their pin polarity at the output register.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } timing_t;

    localparam timing_t TIMING_IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0};

    function automatic logic in_window(input logic [COORD_W-1:0] c,
                                       input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/adv_colour_bars.sv
// Maps a requested column to one of eight vertical colour bars, registered
// once so it lines up with the upstream pixel source's 1-cycle latency.
module adv_colour_bars
    import adv_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic               clk_pixel,
    input  logic               reset,
    input  logic [COORD_W-1:0] i_x,
    output logic [23:0]        o_rgb
);

    logic [2:0]  w_idx;
    logic [23:0] r_rgb;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        w_idx = '0;
        for (int k = 1; k < NUM_BARS; k++) begin
            if (int'(i_x) >= (k * H_ACTIVE) / NUM_BARS) begin
                w_idx = 3'(k);
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= BAR_COLOURS[w_idx];
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/adv_video_timing.sv
// DE/HSYNC/VSYNC/RGB timing generator for the ADV7511 DDR output stage.
// Optional colour bars are built only when ADV_TEST_PATTERN_EN is defined.
module adv_video_timing
    import adv_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic               clk_pixel,
    input  logic               reset,
    input  logic               enable,
    input  logic               test_pattern,
    output logic               pix_req,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    input  logic [23:0]        rgb_in,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               frame_start,
    output logic [23:0]        data_out
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
            $error("adv_video_timing: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
        end
    endgenerate

    logic [COORD_W-1:0] r_hcnt;
    logic [COORD_W-1:0] r_vcnt;
    logic               w_h_last;
    logic               w_v_last;
    timing_t            w_tim0;

    assign w_h_last = (r_hcnt == COORD_W'(H_TOTAL - 1));
    assign w_v_last = (r_vcnt == COORD_W'(V_TOTAL - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (!enable) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Vsync depends only on vcnt, so it can only change when hcnt wraps to 0.
    always_comb begin
        w_tim0    = TIMING_IDLE;
        w_tim0.de = in_window(r_hcnt, 0, H_ACTIVE) && in_window(r_vcnt, 0, V_ACTIVE);
        w_tim0.hs = in_window(r_hcnt, HS_START, HS_END);
        w_tim0.vs = in_window(r_vcnt, VS_START, VS_END);
        w_tim0.fs = w_tim0.de && (r_hcnt == '0) && (r_vcnt == '0);
    end

    timing_t            r_tim1;
    timing_t            r_tim2;
    logic               r_pix_req;
    logic [COORD_W-1:0] r_pix_x;
    logic [COORD_W-1:0] r_pix_y;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_tim1    <= TIMING_IDLE;
            r_tim2    <= TIMING_IDLE;
            r_pix_req <= 1'b0;
            r_pix_x   <= '0;
            r_pix_y   <= '0;
        end else if (!enable) begin
            r_tim1    <= TIMING_IDLE;
            r_tim2    <= TIMING_IDLE;
            r_pix_req <= 1'b0;
            r_pix_x   <= '0;
            r_pix_y   <= '0;
        end else begin
            r_tim1    <= w_tim0;
            r_tim2    <= r_tim1;
            r_pix_req <= w_tim0.de;
            r_pix_x   <= w_tim0.de ? r_hcnt : '0;
            r_pix_y   <= w_tim0.de ? r_vcnt : '0;
        end
    end

    assign pix_req = r_pix_req;
    assign pix_x   = r_pix_x;
    assign pix_y   = r_pix_y;

    logic [23:0] w_pixel;

`ifdef ADV_TEST_PATTERN_EN
    logic [23:0] w_bar_rgb;
    logic        r_tp;

    // Bar colour and its select share the upstream source's 1-cycle delay.
    adv_colour_bars #(
        .H_ACTIVE (H_ACTIVE)
    ) u_colour_bars (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .i_x       (r_pix_x),
        .o_rgb     (w_bar_rgb)
    );

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_tp <= 1'b0;
        end else begin
            r_tp <= test_pattern;
        end
    end

    assign w_pixel = r_tp ? w_bar_rgb : rgb_in;
`else
    logic w_unused_test_pattern;

    assign w_unused_test_pattern = test_pattern;
    assign w_pixel               = rgb_in;
`endif

    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;
    logic [23:0] r_data;

    // Data, DE and both syncs leave on this one edge for the DDR stage.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_de          <= 1'b0;
            r_hsync       <= !HS_POL;
            r_vsync       <= !VS_POL;
            r_frame_start <= 1'b0;
            r_data        <= '0;
        end else if (!enable) begin
            r_de          <= 1'b0;
            r_hsync       <= !HS_POL;
            r_vsync       <= !VS_POL;
            r_frame_start <= 1'b0;
            r_data        <= '0;
        end else begin
            r_de          <= r_tim2.de;
            r_hsync       <= r_tim2.hs ? HS_POL : !HS_POL;
            r_vsync       <= r_tim2.vs ? VS_POL : !VS_POL;
            r_frame_start <= r_tim2.fs;
            r_data        <= r_tim2.de ? w_pixel : '0;
        end
    end

    assign de_out      = r_de;
    assign hsync_out   = r_hsync;
    assign vsync_out   = r_vsync;
    assign frame_start = r_frame_start;
    assign data_out    = r_data;

endmodule

// File: tb/tb_adv_video_timing.sv
// Directed bench for adv_video_timing with a 24x8 total raster and an
// upstream source that echoes {pix_y, pix_x} one cycle after pix_req.
module tb_adv_video_timing;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

`ifdef ADV_TEST_PATTERN_EN
    localparam bit BARS_BUILT = 1'b1;
`else
    localparam bit BARS_BUILT = 1'b0;
`endif

    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        enable;
    logic        test_pattern;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [23:0] rgb_in = '0;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        frame_start;
    logic [23:0] data_out;

    int total = 0;
    int bad   = 0;

    adv_video_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL   (1'b1), .VS_POL (1'b1)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .enable       (enable),
        .test_pattern (test_pattern),
        .pix_req      (pix_req),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .rgb_in       (rgb_in),
        .de_out       (de_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .frame_start  (frame_start),
        .data_out     (data_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Upstream frame source: registers the requested coordinate as its pixel.
    always @(posedge clk_pixel) rgb_in <= pix_req ? {pix_y, pix_x} : 24'h0;

    function automatic logic [23:0] exp_bar(input int x);
        case (x / 2)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Checks one whole frame, starting at the sample where frame_start is due.
    task automatic check_frame(input string name, input bit use_bars);
        for (int i = 0; i < FT; i++) begin
            int          px;
            int          ln;
            int          j;
            logic        e_de;
            logic        e_req;
            logic [23:0] e_data;
            logic [27:0] want_out;
            logic [24:0] want_pix;
            px     = i % HT;
            ln     = i / HT;
            e_de   = (px < HA) && (ln < VA);
            e_data = !e_de ? 24'h0 : (use_bars ? exp_bar(px) : {12'(ln), 12'(px)});
            want_out = {e_de,
                        (px >= HA + HF) && (px < HA + HF + HS),
                        (ln >= VA + VF) && (ln < VA + VF + VS),
                        i == 0,
                        e_data};
            total++;
            if ({de_out, hsync_out, vsync_out, frame_start, data_out} !== want_out) begin
                bad++;
                $display("FAIL %s_out cycle %0d: got %h want %h", name, i,
                         {de_out, hsync_out, vsync_out, frame_start, data_out}, want_out);
            end
            j        = (i + 2) % FT;
            e_req    = ((j % HT) < HA) && ((j / HT) < VA);
            want_pix = {e_req, e_req ? 12'(j / HT) : 12'h0, e_req ? 12'(j % HT) : 12'h0};
            total++;
            if ({pix_req, pix_y, pix_x} !== want_pix) begin
                bad++;
                $display("FAIL %s_pix cycle %0d: got %h want %h", name, i,
                         {pix_req, pix_y, pix_x}, want_pix);
            end
            @(negedge clk_pixel);
        end
    endtask

    task automatic check_idle(input string name);
        total++;
        if ({pix_req, pix_x, pix_y, de_out, hsync_out, vsync_out, frame_start, data_out} !== '0) begin
            bad++;
            $display("FAIL %s: got req=%b x=%h y=%h de=%b hs=%b vs=%b fs=%b data=%h want all 0",
                     name, pix_req, pix_x, pix_y, de_out, hsync_out, vsync_out, frame_start, data_out);
        end
    endtask

    // Three edges after release/enable, the first output must be (0,0).
    task automatic wait_first_pixel(input string name);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_pixel);
            total++;
            if ({de_out, frame_start} !== 2'b00) begin
                bad++;
                $display("FAIL %s_early edge %0d: got de/fs %b want 00", name, k + 1,
                         {de_out, frame_start});
            end
        end
        @(negedge clk_pixel);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        test_pattern = 1'b0;
        repeat (2) @(negedge clk_pixel);
        check_idle("reset_state");
    endtask

    task automatic test_line_timing();
        reset  = 1'b0;
        enable = 1'b1;
        wait_first_pixel("release");
        check_frame("frame0", 1'b0);
    endtask

    task automatic test_frame_period();
        check_frame("frame1", 1'b0);
    endtask

    task automatic test_enable_drop();
        repeat (2 * HT + 5) @(negedge clk_pixel);
        total++;
        if (de_out !== 1'b1) begin
            bad++;
            $display("FAIL drop_pre_de: got %b want 1", de_out);
        end
        enable = 1'b0;
        repeat (3) @(negedge clk_pixel);
        check_idle("drop_idle");
        repeat (20) @(negedge clk_pixel);
        check_idle("drop_hold");
        enable = 1'b1;
        wait_first_pixel("reenable");
        check_frame("restart", 1'b0);
    endtask

    task automatic test_reset_mid_active();
        repeat (HT + 4) @(negedge clk_pixel);
        total++;
        if (de_out !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_de: got %b want 1", de_out);
        end
        #2 reset = 1'b1;
        #1 check_idle("rst_async");
        @(negedge clk_pixel);
        check_idle("rst_held");
        reset = 1'b0;
        wait_first_pixel("rst_release");
        check_frame("after_reset", 1'b0);
    endtask

    task automatic test_pattern_bars();
        enable       = 1'b0;
        test_pattern = 1'b1;
        repeat (2) @(negedge clk_pixel);
        enable = 1'b1;
        wait_first_pixel("bars_start");
        check_frame("bars", BARS_BUILT);
        test_pattern = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_period();
        test_enable_drop();
        test_reset_mid_active();
        test_pattern_bars();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
